pipelined_adder: RTL and testbench

//   Parametrised, pipelined add/subtract unit; successor to the datapath's 32-bit

---
 rtl/pipelined_adder_if.sv | 26 ++
 rtl/pipelined_adder.sv | 121 ++++++++++++
 tb/tb_pipelined_adder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for pipelined_adder
`timescale 1ns/1ps
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic             sub_i;
  logic [WIDTH-1:0] data1_in;
  logic [WIDTH-1:0] data2_in;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_out;
  logic             carry_o;
  logic             overflow_o;

  modport master (
    output valid_i, sub_i, data1_in, data2_in, ready_i,
    input  ready_o, valid_o, data_out, carry_o, overflow_o
  );

  modport slave (
    input  valid_i, sub_i, data1_in, data2_in, ready_i,
    output ready_o, valid_o, data_out, carry_o, overflow_o
  );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep carry-chained add/sub with valid/ready handshake
// Build option ADDER_SAT_EN clamps data_out to signed max/min on overflow.
`timescale 1ns/1ps
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pipelined_adder_if.slave    bus
);
  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic              ovf_q, ovf_d;

  // Per-stage inputs: stage 0 sees the ports, stage k sees stage k-1 registers.
  logic [WIDTH-1:0]  a_s   [STAGES];
  logic [WIDTH-1:0]  b_s   [STAGES];
  logic [WIDTH-1:0]  r_s   [STAGES];
  logic [SW:0]       sum_s [STAGES];
  logic [STAGES-1:0] c_s;
  logic [STAGES-1:0] v_s;

  logic              adv;
  logic              ovf_now;
  logic [WIDTH-1:0]  res_last;

  assign adv            = ~vld_q[L] | bus.ready_i;
  assign bus.ready_o    = adv;
  assign bus.valid_o    = vld_q[L];
  assign bus.data_out   = res_q[L];
  assign bus.carry_o    = cy_q[L];
  assign bus.overflow_o = ovf_q;

  always_comb begin
    a_s[0] = bus.data1_in;
    b_s[0] = bus.sub_i ? ~bus.data2_in : bus.data2_in;
    c_s[0] = bus.sub_i;
    r_s[0] = '0;
    v_s[0] = bus.valid_i;
    for (int k = 1; k < STAGES; k++) begin
      a_s[k] = a_q[k-1];
      b_s[k] = b_q[k-1];
      c_s[k] = cy_q[k-1];
      r_s[k] = res_q[k-1];
      v_s[k] = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sum_s[k] = {1'b0, a_s[k][k*SW +: SW]} + {1'b0, b_s[k][k*SW +: SW]}
               + {{SW{1'b0}}, c_s[k]};
    end
  end

  // Same-sign operands (B already conditioned) producing a different-sign result.
  always_comb begin
    ovf_now  = (a_s[L][WIDTH-1] == b_s[L][WIDTH-1]) &&
               (sum_s[L][SW-1] != a_s[L][WIDTH-1]);
    res_last = r_s[L];
    res_last[L*SW +: SW] = sum_s[L][SW-1:0];
`ifdef ADDER_SAT_EN
    if (ovf_now) begin
      res_last = a_s[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    vld_d = vld_q;
    cy_d  = cy_q;
    ovf_d = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      res_d[k] = res_q[k];
    end
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_d[k] = v_s[k];
        a_d[k]   = a_s[k];
        b_d[k]   = b_s[k];
        cy_d[k]  = sum_s[k][SW];
        res_d[k] = r_s[k];
        res_d[k][k*SW +: SW] = sum_s[k][SW-1:0];
      end
      res_d[L] = res_last;
      ovf_d    = ovf_now;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - random and directed checks of pipelined_adder against a behavioural model
`timescale 1ns/1ps
module tb_pipelined_adder;
  localparam int W = 32;
  localparam int S = 2;

`ifdef ADDER_SAT_EN
  localparam logic [31:0] MAXP1_DATA = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] MAXP1_DATA = 32'h8000_0000;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  logic [33:0] exp_q [$];
  int          emit_cyc [$];
  logic [31:0] emit_dat [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // {overflow, carry, data} from signed/unsigned arithmetic on the operands
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint      sa, sb, s;
    logic [32:0] u;
    logic        ovf, c;
    logic [31:0] d;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    s   = sub ? sa - sb : sa + sb;
    ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    u   = {1'b0, a} + {1'b0, b};
    c   = sub ? (a >= b) : u[32];
    d   = s[31:0];
`ifdef ADDER_SAT_EN
    if (ovf) d = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {ovf, c, d};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      check("reset_valid_o", 64'(bus.valid_o), 64'd0);
    end else begin
      check("ready_o", 64'(bus.ready_o), 64'(!bus.valid_o || bus.ready_i));
      if (bus.valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid_o", 64'(bus.valid_o), 64'd0);
        end else begin
          check("result", 64'({bus.overflow_o, bus.carry_o, bus.data_out}), 64'(exp_q[0]));
          if (bus.ready_i) begin
            void'(exp_q.pop_front());
            emit_cyc.push_back(cyc);
            emit_dat.push_back(bus.data_out);
          end
        end
      end
      if (bus.valid_i && bus.ready_o)
        exp_q.push_back(model(bus.data1_in, bus.data2_in, bus.sub_i));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic accepted;
    accepted     = 1'b0;
    bus.valid_i  = 1'b1;
    bus.data1_in = a;
    bus.data2_in = b;
    bus.sub_i    = sub;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) check("send_accept", 64'(accepted), 64'd1);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [33:0] exp);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    bus.ready_i = 1'b1;
    send(a, b, sub);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        got = 1'b1;
        break;
      end
      n++;
    end
    check({name, "_seen"}, 64'(got), 64'd1);
    check({name, "_latency"}, 64'(n), 64'(S - 1));
    check({name, "_value"}, 64'({bus.overflow_o, bus.carry_o, bus.data_out}), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold;
    logic [31:0] ra, rb;
    logic        done;
    bus.valid_i  = 1'b0;
    bus.sub_i    = 1'b0;
    bus.data1_in = '0;
    bus.data2_in = '0;
    bus.ready_i  = 1'b1;

    check("pin_wrap",   64'(model(32'hFFFF_FFFF, 32'h1, 1'b0)), 64'({1'b0, 1'b1, 32'h0000_0000}));
    check("pin_maxp1",  64'(model(32'h7FFF_FFFF, 32'h1, 1'b0)), 64'({1'b1, 1'b0, MAXP1_DATA}));
    check("pin_5m7",    64'(model(32'd5, 32'd7, 1'b1)),         64'({1'b0, 1'b0, 32'hFFFF_FFFE}));
    check("pin_7m5",    64'(model(32'd7, 32'd5, 1'b1)),         64'({1'b0, 1'b1, 32'h0000_0002}));

    #1 rst_n = 1'b0;
    #1;
    check("rst_valid_o",  64'(bus.valid_o),    64'd0);
    check("rst_data_out", 64'(bus.data_out),   64'd0);
    check("rst_carry_o",  64'(bus.carry_o),    64'd0);
    check("rst_ovf_o",    64'(bus.overflow_o), 64'd0);
    check("rst_ready_o",  64'(bus.ready_o),    64'd1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_one("wrap",  32'hFFFF_FFFF, 32'h1, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
    run_one("maxp1", 32'h7FFF_FFFF, 32'h1, 1'b0, {1'b1, 1'b0, MAXP1_DATA});
    run_one("sub57", 32'd5, 32'd7, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    run_one("sub75", 32'd7, 32'd5, 1'b1, {1'b0, 1'b1, 32'h0000_0002});

    // back-to-back: results on consecutive cycles, in order
    emit_cyc.delete();
    emit_dat.delete();
    for (int i = 1; i <= 8; i++) send(32'(i), 32'(i), 1'b0);
    repeat (S + 3) @(posedge clk);
    #1;
    check("b2b_count", 64'(emit_dat.size()), 64'd8);
    if (emit_dat.size() == 8) begin
      check("b2b_span", 64'(emit_cyc[7] - emit_cyc[0]), 64'd7);
      for (int i = 0; i < 8; i++) check("b2b_data", 64'(emit_dat[i]), 64'(2 * (i + 1)));
    end

    // downstream stall with a full pipe
    emit_dat.delete();
    bus.ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) send(32'(10 + i), 32'd100, 1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        check("stall_ready_o", 64'(bus.ready_o), 64'd0);
        check("stall_valid_o", 64'(bus.valid_o), 64'd1);
        hold = bus.data_out;
        repeat (3) begin
          @(negedge clk);
          check("stall_hold", 64'(bus.data_out), 64'(hold));
        end
        @(posedge clk);
        #1 bus.ready_i = 1'b1;
      end
    join
    repeat (S + 3) @(posedge clk);
    #1;
    check("stall_count", 64'(emit_dat.size()), 64'd3);
    if (emit_dat.size() == 3)
      for (int i = 0; i < 3; i++) check("stall_data", 64'(emit_dat[i]), 64'(110 + i));

    // randomized traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          case ($urandom_range(0, 7))
            0:       ra = 32'hFFFF_FFFF;
            1:       ra = 32'h7FFF_FFFF;
            2:       ra = 32'h8000_0000;
            default: ra = $urandom;
          endcase
          rb = ($urandom_range(0, 5) == 0) ? 32'(($urandom_range(0, 1) == 0) ? 1 : 0) : $urandom;
          send(ra, rb, 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.ready_i = 1'b1;
    repeat (S + 4) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    // asynchronous reset mid-stream
    send(32'd1, 32'd1, 1'b0);
    send(32'd2, 32'd2, 1'b0);
    send(32'd3, 32'd3, 1'b0);
    check("rst_pre_valid", 64'(bus.valid_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid_o",  64'(bus.valid_o),  64'd0);
    check("arst_data_out", 64'(bus.data_out), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    emit_dat.delete();
    repeat (8) @(posedge clk);
    #1;
    check("arst_no_stale", 64'(emit_dat.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
